gc_response_rx: RTL

- Receives the controller's reply on the shared single-wire joybus line after the query transmitter releases it.
- Measures low-pulse widths in 100 MHz cycles, decodes 64 data bits plus the stop bit, and presents the word with a one-cycle valid strobe.
- Reports missing or malformed replies to the controller-state logic.
- Sits directly downstream of the query sender and consumes its send flag and the same data pin.

---
 rtl/gc_response_rx.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/gc_response_rx.sv
// gc_response_rx: joybus controller-reply receiver that decodes 64 data bits plus a stop bit from low-pulse widths.
// Optional macro GC_RX_DECODE_EN adds registered button/stick/trigger field outputs.
module gc_response_rx #(
   parameter int CLK_PER_US   = 100,
   parameter int NUM_BITS     = 64,
   parameter int BIT_THRESH   = 200,
   parameter int LOW_MAX      = 500,
   parameter int HIGH_MAX     = 500,
   parameter int RESP_TIMEOUT = 10000
) (
   input  logic                clk100mhz,
   input  logic                reset,
   input  logic                data_in,
   input  logic                send,
   output logic [NUM_BITS-1:0] resp_data,
   output logic                resp_valid,
   output logic                busy,
   output logic                rx_error,
   output logic [1:0]          err_code
`ifdef GC_RX_DECODE_EN
   ,
   output logic [15:0]         buttons,
   output logic [7:0]          joy_x,
   output logic [7:0]          joy_y,
   output logic [7:0]          cstick_x,
   output logic [7:0]          cstick_y,
   output logic [7:0]          trig_l,
   output logic [7:0]          trig_r
`endif
);

   localparam int CNT_W = 14;
   localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(BIT_THRESH);
   localparam logic [CNT_W-1:0] LOW_MAX_C = CNT_W'(LOW_MAX);
   localparam logic [CNT_W-1:0] HI_MAX_C  = CNT_W'(HIGH_MAX);
   localparam logic [CNT_W-1:0] TMO_C     = CNT_W'(RESP_TIMEOUT);
   localparam logic [6:0]       NBITS_C   = 7'(NUM_BITS);

   localparam logic [1:0] ERR_NONE   = 2'd0;
   localparam logic [1:0] ERR_NORESP = 2'd1;
   localparam logic [1:0] ERR_LOW    = 2'd2;
   localparam logic [1:0] ERR_HIGH   = 2'd3;

   // Timing is configured purely in cycles; the clock rate only has to be sane.
   if (CLK_PER_US < 1) begin : g_bad_clk_per_us
   end

   typedef enum logic [2:0] {IDLE, ARMED, WAIT_START, LOW, HIGH, ERROR} state_t;

   state_t              state;
   logic                sync1, sync2, sync3;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cnt_inc;
   logic [6:0]          bit_idx;
   logic [NUM_BITS-1:0] shreg;
   logic                fall, rise;

   // NOTE: the synchronizer resets to 1 (the idle line level) so leaving reset never fakes a falling edge.
   always_ff @(posedge clk100mhz or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         sync3 <= 1'b1;
      end else begin
         sync1 <= data_in;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign fall = sync3 & ~sync2;
   assign rise = ~sync3 & sync2;

   // cnt_inc is the pulse width including the current cycle, so a W-cycle pin pulse measures as W.
   assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

   // NOTE: non-blocking (<=) in every clocked block so all flops sample pre-edge values.
   always_ff @(posedge clk100mhz or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         resp_data  <= '0;
         resp_valid <= 1'b0;
         busy       <= 1'b0;
         rx_error   <= 1'b0;
         err_code   <= ERR_NONE;
`ifdef GC_RX_DECODE_EN
         buttons    <= '0;
         joy_x      <= '0;
         joy_y      <= '0;
         cstick_x   <= '0;
         cstick_y   <= '0;
         trig_l     <= '0;
         trig_r     <= '0;
`endif
      end else begin
         resp_valid <= 1'b0;
         rx_error   <= 1'b0;
         cnt        <= cnt_inc;
         unique case (state)
            IDLE: begin
               if (send) begin
                  state <= ARMED;
                  busy  <= 1'b1;
               end
            end
            ARMED: begin
               if (!send) begin
                  state    <= WAIT_START;
                  cnt      <= '0;
                  err_code <= ERR_NONE;
               end
            end
            WAIT_START: begin
               if (send) begin
                  state <= ARMED;
               end else if (fall) begin
                  state   <= LOW;
                  cnt     <= '0;
                  bit_idx <= '0;
               end else if (cnt_inc == TMO_C) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  rx_error <= 1'b1;
                  err_code <= ERR_NORESP;
               end
            end
            LOW: begin
               if (send) begin
                  state <= ARMED;
               end else if (rise) begin
                  if (bit_idx < NBITS_C) begin
                     shreg   <= {shreg[NUM_BITS-2:0], (cnt_inc < THRESH_C)};
                     bit_idx <= bit_idx + 1'b1;
                     cnt     <= '0;
                     state   <= HIGH;
                  end else if (cnt_inc < THRESH_C) begin
                     resp_data  <= shreg;
                     resp_valid <= 1'b1;
                     busy       <= 1'b0;
                     state      <= IDLE;
`ifdef GC_RX_DECODE_EN
                     buttons    <= shreg[63:48];
                     joy_x      <= shreg[47:40];
                     joy_y      <= shreg[39:32];
                     cstick_x   <= shreg[31:24];
                     cstick_y   <= shreg[23:16];
                     trig_l     <= shreg[15:8];
                     trig_r     <= shreg[7:0];
`endif
                  end else begin
                     err_code <= ERR_LOW;
                     state    <= ERROR;
                  end
               end else if (cnt_inc > LOW_MAX_C) begin
                  err_code <= ERR_LOW;
                  state    <= ERROR;
               end
            end
            HIGH: begin
               if (send) begin
                  state <= ARMED;
               end else if (fall) begin
                  cnt   <= '0;
                  state <= LOW;
               end else if (cnt_inc > HI_MAX_C) begin
                  err_code <= ERR_HIGH;
                  state    <= ERROR;
               end
            end
            ERROR: begin
               rx_error <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
